// File: rtl/swd_pkg.sv
// Shared definitions for the SWD transfer path: target ACK codes and the
// transfer sequencer state encoding.
package swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_LAUNCH = 3'd2,
        S_BUSY   = 3'd3,
        S_EVAL   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/swd_xfer_ctl.sv
// Single DP/AP transfer sequencer in front of the SWD pin engine: launches
// attempts with a level go, retries WAIT acks, watchdogs a stalled engine.
module swd_xfer_ctl
    import swd_pkg::*;
#(
    parameter int                RETRY_W     = 16,
    parameter int                TOUT_W      = 20,
    parameter logic [TOUT_W-1:0] TOUT_CYCLES = 20'hFFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_addr32,
    input  logic               cmd_rnw,
    input  logic               cmd_apndp,
    input  logic [31:0]        cmd_wdata,
    input  logic [RETRY_W-1:0] wait_retry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_perr,
    output logic               rsp_timeout,
    output logic [RETRY_W-1:0] rsp_retries,
    output logic [1:0]         addr32,
    output logic               rnw,
    output logic               apndp,
    output logic [31:0]        dwrite,
    output logic               go,
    input  logic               idle,
    input  logic [2:0]         ack,
    input  logic [31:0]        dread,
    input  logic               perr
);

    localparam logic [TOUT_W-1:0] WDOG_LAST = TOUT_CYCLES - TOUT_W'(1);

    state_t             state_reg, state_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [RETRY_W-1:0] limit_reg, limit_next;
    logic [TOUT_W-1:0]  wdog_reg, wdog_next;
    logic [1:0]         addr_reg, addr_next;
    logic               rnw_reg, rnw_next;
    logic               apndp_reg, apndp_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [2:0]         ack_reg, ack_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic               perr_reg, perr_next;
    logic               tout_reg, tout_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            retry_reg <= '0;
            limit_reg <= '0;
            wdog_reg  <= '0;
            addr_reg  <= '0;
            rnw_reg   <= 1'b0;
            apndp_reg <= 1'b0;
            wdata_reg <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
            perr_reg  <= 1'b0;
            tout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            limit_reg <= limit_next;
            wdog_reg  <= wdog_next;
            addr_reg  <= addr_next;
            rnw_reg   <= rnw_next;
            apndp_reg <= apndp_next;
            wdata_reg <= wdata_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
            perr_reg  <= perr_next;
            tout_reg  <= tout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        limit_next = limit_reg;
        wdog_next  = wdog_reg;
        addr_next  = addr_reg;
        rnw_next   = rnw_reg;
        apndp_next = apndp_reg;
        wdata_next = wdata_reg;
        ack_next   = ack_reg;
        rdata_next = rdata_reg;
        perr_next  = perr_reg;
        tout_next  = tout_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr32;
                    rnw_next   = cmd_rnw;
                    apndp_next = cmd_apndp;
                    wdata_next = cmd_wdata;
                    limit_next = wait_retry;
                    retry_next = '0;
                    state_next = S_PREP;
                end
            end
            S_PREP: begin
                wdog_next = '0;
                if (idle) state_next = S_LAUNCH;
            end
            S_LAUNCH, S_BUSY: begin
                wdog_next = wdog_reg + TOUT_W'(1);
                // Watchdog wins over any engine progress seen in its final cycle.
                if (wdog_reg == WDOG_LAST) begin
                    tout_next  = 1'b1;
                    ack_next   = 3'b000;
                    rdata_next = '0;
                    perr_next  = 1'b0;
                    state_next = S_RESP;
                end else if (state_reg == S_LAUNCH && !idle) begin
                    state_next = S_BUSY;
                end else if (state_reg == S_BUSY && idle) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (ack == ACK_WAIT && retry_reg < limit_reg) begin
                    if (retry_reg != '1) retry_next = retry_reg + RETRY_W'(1);
                    state_next = S_PREP;
                end else begin
                    tout_next  = 1'b0;
                    ack_next   = ack;
                    rdata_next = (rnw_reg && ack == ACK_OK) ? dread : 32'd0;
                    perr_next  = rnw_reg && perr;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake strobes and go are masked by rst so a reset takes effect in the same cycle.
    assign cmd_ready   = (state_reg == S_IDLE) && !rst;
    assign go          = (state_reg == S_LAUNCH) && !rst;
    assign rsp_valid   = (state_reg == S_RESP) && !rst;
    assign rsp_ack     = ack_reg;
    assign rsp_rdata   = rdata_reg;
    assign rsp_perr    = perr_reg;
    assign rsp_timeout = tout_reg;
    assign rsp_retries = retry_reg;
    assign addr32      = addr_reg;
    assign rnw         = rnw_reg;
    assign apndp       = apndp_reg;
    assign dwrite      = wdata_reg;

endmodule

// File: tb/tb_swd_xfer_ctl.sv
// Directed bench for swd_xfer_ctl with a small scripted SWD engine model.
module tb_swd_xfer_ctl;
    import swd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_addr32 = '0;
    logic        cmd_rnw = 1'b0;
    logic        cmd_apndp = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [15:0] wait_retry = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;
    logic        rsp_timeout;
    logic [15:0] rsp_retries;
    logic [1:0]  addr32;
    logic        rnw;
    logic        apndp;
    logic [31:0] dwrite;
    logic        go;
    logic        idle = 1'b1;
    logic [2:0]  ack = 3'b000;
    logic [31:0] dread = '0;
    logic        perr = 1'b0;

    always #5 clk = ~clk;

    swd_xfer_ctl #(
        .RETRY_W(16), .TOUT_W(20), .TOUT_CYCLES(20'd100)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr32(cmd_addr32), .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp),
        .cmd_wdata(cmd_wdata), .wait_retry(wait_retry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
        .rsp_timeout(rsp_timeout), .rsp_retries(rsp_retries),
        .addr32(addr32), .rnw(rnw), .apndp(apndp), .dwrite(dwrite),
        .go(go), .idle(idle), .ack(ack), .dread(dread), .perr(perr)
    );

    // Engine model: sees go while idle, drops idle 2 clocks later, completes 5 clocks after that.
    logic [2:0]  ack_seq [0:7];
    int          eng_att = 0;
    int          att_base = 0;
    bit          eng_stuck = 1'b0;
    logic [31:0] eng_dread = '0;
    logic        eng_perr = 1'b0;

    always begin
        @(posedge clk);
        if (go && idle && !eng_stuck) begin
            repeat (2) @(posedge clk);
            idle <= 1'b0;
            repeat (5) @(posedge clk);
            ack     <= ack_seq[(eng_att - att_base) & 7];
            dread   <= eng_dread;
            perr    <= eng_perr;
            eng_att <= eng_att + 1;
            idle    <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int go_rises, go_high, dw_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic script(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                          input logic [2:0] rest, input logic [31:0] rd, input logic pe);
        ack_seq[0] = a0;
        ack_seq[1] = a1;
        ack_seq[2] = a2;
        for (int i = 3; i < 8; i++) ack_seq[i] = rest;
        eng_dread = rd;
        eng_perr  = pe;
        att_base  = eng_att;
    endtask

    task automatic start_cmd(input logic [1:0] a, input logic r, input logic ap,
                             input logic [31:0] wd, input logic [15:0] wr);
        int n;
        @(negedge clk);
        cmd_addr32 = a;
        cmd_rnw    = r;
        cmd_apndp  = ap;
        cmd_wdata  = wd;
        wait_retry = wr;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the command bus so that unlatched fields would show up.
        cmd_valid  = 1'b0;
        cmd_addr32 = ~a;
        cmd_rnw    = ~r;
        cmd_apndp  = ~ap;
        cmd_wdata  = 32'hDEADBEEF;
        wait_retry = 16'd0;
    endtask

    task automatic wait_rsp(input logic [31:0] wd_exp);
        int n;
        logic go_prev;
        go_rises = 0;
        go_high  = 0;
        dw_bad   = 0;
        go_prev  = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (go && !go_prev) go_rises++;
            if (go) go_high++;
            go_prev = go;
            if (dwrite !== wd_exp) dw_bad++;
            n++;
        end
        check("rsp_valid_in_time", {31'd0, rsp_valid}, 32'd1);
        $display("xfer: ack=%b rdata=%h perr=%0d tout=%0d retries=%0d go_pulses=%0d",
                 rsp_ack, rsp_rdata, rsp_perr, rsp_timeout, rsp_retries, go_rises);
    endtask

    task automatic consume;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "simulation hung");
    end

    initial begin
        int n;
        int bad;
        logic [31:0] snap;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_go", {31'd0, go}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_ack", {29'd0, rsp_ack}, 32'd0);
        check("rst_dwrite", dwrite, 32'd0);
        check("rst_addr32", {30'd0, addr32}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // DP read, single OK attempt
        script(ACK_OK, ACK_OK, ACK_OK, ACK_OK, 32'h2BA01477, 1'b0);
        start_cmd(2'd0, 1'b1, 1'b0, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("rd_ack", {29'd0, rsp_ack}, 32'd1);
        check("rd_rdata", rsp_rdata, 32'h2BA01477);
        check("rd_perr", {31'd0, rsp_perr}, 32'd0);
        check("rd_retries", {16'd0, rsp_retries}, 32'd0);
        check("rd_go_pulses", go_rises, 1);
        check("rd_fields", {28'd0, addr32, rnw, apndp}, {28'd0, 2'd0, 1'b1, 1'b0});
        check("rd_cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
        consume();

        // AP write, WAIT WAIT OK
        script(ACK_WAIT, ACK_WAIT, ACK_OK, ACK_OK, 32'h55AA55AA, 1'b0);
        start_cmd(2'd1, 1'b0, 1'b1, 32'h23000052, 16'd5);
        wait_rsp(32'h23000052);
        check("wr_go_pulses", go_rises, 3);
        check("wr_ack", {29'd0, rsp_ack}, 32'd1);
        check("wr_retries", {16'd0, rsp_retries}, 32'd2);
        check("wr_rdata", rsp_rdata, 32'd0);
        check("wr_dwrite_unstable", dw_bad, 0);
        check("wr_fields", {28'd0, addr32, rnw, apndp}, {28'd0, 2'd1, 1'b0, 1'b1});
        consume();

        // Persistent WAIT exhausts retry limit of 3
        script(ACK_WAIT, ACK_WAIT, ACK_WAIT, ACK_WAIT, 32'h0, 1'b0);
        start_cmd(2'd2, 1'b1, 1'b1, 32'h0, 16'd3);
        wait_rsp(32'h0);
        check("wx_go_pulses", go_rises, 4);
        check("wx_ack", {29'd0, rsp_ack}, 32'd2);
        check("wx_retries", {16'd0, rsp_retries}, 32'd3);
        consume();

        // wait_retry=0 reports the first WAIT
        script(ACK_WAIT, ACK_OK, ACK_OK, ACK_OK, 32'h0, 1'b0);
        start_cmd(2'd0, 1'b1, 1'b0, 32'h0, 16'd0);
        wait_rsp(32'h0);
        check("w0_go_pulses", go_rises, 1);
        check("w0_ack", {29'd0, rsp_ack}, 32'd2);
        check("w0_retries", {16'd0, rsp_retries}, 32'd0);
        consume();

        // FAULT is never retried; read data suppressed
        script(ACK_FAULT, ACK_OK, ACK_OK, ACK_OK, 32'hCAFEF00D, 1'b0);
        start_cmd(2'd3, 1'b1, 1'b1, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("flt_go_pulses", go_rises, 1);
        check("flt_ack", {29'd0, rsp_ack}, 32'd4);
        check("flt_rdata", rsp_rdata, 32'd0);
        consume();

        // Invalid ACK reported verbatim
        script(3'b111, ACK_OK, ACK_OK, ACK_OK, 32'h12121212, 1'b0);
        start_cmd(2'd0, 1'b1, 1'b0, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("inv_go_pulses", go_rises, 1);
        check("inv_ack", {29'd0, rsp_ack}, 32'd7);
        consume();

        // Read parity error
        script(ACK_OK, ACK_OK, ACK_OK, ACK_OK, 32'h0BADF00D, 1'b1);
        start_cmd(2'd1, 1'b1, 1'b0, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("pe_perr", {31'd0, rsp_perr}, 32'd1);
        check("pe_rdata", rsp_rdata, 32'h0BADF00D);
        consume();
        eng_perr = 1'b0;

        // Engine never leaves idle: watchdog after 100 clocks of go
        script(ACK_OK, ACK_OK, ACK_OK, ACK_OK, 32'h11111111, 1'b0);
        eng_stuck = 1'b1;
        start_cmd(2'd0, 1'b1, 1'b0, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("to_go_high_cycles", go_high, 100);
        check("to_timeout", {31'd0, rsp_timeout}, 32'd1);
        check("to_ack", {29'd0, rsp_ack}, 32'd0);
        check("to_rdata", rsp_rdata, 32'd0);
        check("to_go_dropped", {31'd0, go}, 32'd0);
        consume();
        eng_stuck = 1'b0;

        // Normal read after timeout
        script(ACK_OK, ACK_OK, ACK_OK, ACK_OK, 32'hA5A5C3C3, 1'b0);
        start_cmd(2'd2, 1'b1, 1'b0, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("ato_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("ato_ack", {29'd0, rsp_ack}, 32'd1);
        check("ato_rdata", rsp_rdata, 32'hA5A5C3C3);

        // Hold off the response consumer for 50 cycles
        snap = rsp_rdata;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_rdata !== snap || rsp_ack !== 3'b001
                || rsp_timeout !== 1'b0 || addr32 !== 2'd2)
                bad++;
        end
        check("stall_unstable_cycles", bad, 0);
        consume();
        #1;
        check("stall_released_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset while engine is busy abandons the transfer
        script(ACK_OK, ACK_OK, ACK_OK, ACK_OK, 32'h77777777, 1'b0);
        start_cmd(2'd3, 1'b1, 1'b1, 32'h0, 16'd5);
        n = 0;
        while (idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rb_engine_started", {31'd0, idle}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rb_go", {31'd0, go}, 32'd0);
        check("rb_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rb_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rb_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("rb_rsp_ack_cleared", {29'd0, rsp_ack}, 32'd0);
        bad = 0;
        n = 0;
        while (!idle && n < 100) begin
            @(negedge clk);
            if (rsp_valid || go) bad++;
            n++;
        end
        repeat (5) @(negedge clk);
        if (rsp_valid) bad++;
        check("rb_no_response", bad, 0);

        // Clean transfer after reset
        script(ACK_OK, ACK_OK, ACK_OK, ACK_OK, 32'h0F0F0F0F, 1'b0);
        start_cmd(2'd1, 1'b1, 1'b0, 32'h0, 16'd5);
        wait_rsp(32'h0);
        check("pr_ack", {29'd0, rsp_ack}, 32'd1);
        check("pr_rdata", rsp_rdata, 32'h0F0F0F0F);
        consume();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/swd_xfer_ctl.md
Name: swd_xfer_ctl

Overview:
Transfer sequencer directly upstream of the SWD pin engine (swdIF). It accepts single DP/AP register transfer commands over a valid/ready handshake, and drives the engine's go/idle protocol. It retries WAIT acknowledges up to a configurable limit, guards against a stalled engine with a watchdog, and returns one result per command over a second valid/ready handshake. The command decoder (CMSIS-DAP style transfer handler) is its upstream client.

Parameters:
RETRY_W, 16, width of retry limit and retry count
TOUT_W, 20, width of watchdog counter
TOUT_CYCLES, 20'hFFFFF, clk cycles allowed per engine attempt before timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_addr32  in  2  register address bits 3:2
cmd_rnw  in  1  1=read, 0=write
cmd_apndp  in  1  1=AP, 0=DP
cmd_wdata  in  32  write data
wait_retry  in  RETRY_W  max WAIT retries; 0 = no retry
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed when rsp_valid&&rsp_ready
rsp_ack  out  3  final ACK from target
rsp_rdata  out  32  read data (0 for writes)
rsp_perr  out  1  read parity error
rsp_timeout  out  1  watchdog expired
rsp_retries  out  RETRY_W  WAIT retries performed
addr32  out  2  to engine
rnw  out  1  to engine
apndp  out  1  to engine
dwrite  out  32  to engine
go  out  1  to engine trigger
idle  in  1  from engine
ack  in  3  from engine
dread  in  32  from engine
perr  in  1  from engine

Behaviour:
- Reset: state S_IDLE; cmd_ready=0 while rst, then 1; rsp_valid=0; go=0; rsp_ack=0, rsp_rdata=0, rsp_perr=0, rsp_timeout=0, rsp_retries=0; addr32/rnw/apndp/dwrite=0. Reset mid-transfer abandons it: no response is produced and go drops the same cycle.
- cmd_ready=1 only in S_IDLE. On accept, cmd fields are latched into addr32/rnw/apndp/dwrite; those remain stable until the response is consumed. wait_retry is sampled at accept.
- The engine samples go only on its internal falling-edge strobe. go is therefore a level held until the engine leaves idle.
- States:
  - S_IDLE: on accept, clear retry count, go to S_PREP.
  - S_PREP: wait idle==1 (engine may still be cooling); then S_LAUNCH. Watchdog cleared.
  - S_LAUNCH: go=1; on idle==0, go=0 and move to S_BUSY.
  - S_BUSY: wait idle==1; then S_EVAL.
  - S_EVAL, one cycle:
    - If ack==3'b010 (WAIT) and retries<wait_retry: retries+1, go to S_PREP.
    - Otherwise capture rsp_ack=ack, rsp_rdata=(rnw && ack==3'b001)?dread:0, rsp_perr=rnw&&perr, and go to S_RESP.
  - S_RESP: rsp_valid=1; on rsp_ready, go to S_IDLE. cmd_ready rises the following cycle, so there is no back-to-back accept in the same cycle.
- Watchdog: counts clk in S_LAUNCH and S_BUSY and clears on S_PREP entry. At TOUT_CYCLES it forces go=0, rsp_timeout=1, rsp_ack=3'b000, rsp_rdata=0, and moves to S_RESP. Retries are not attempted after a timeout.
- The retry counter saturates at its maximum (cannot exceed wait_retry anyway). wait_retry=0 reports the first WAIT immediately with rsp_retries=0.
- FAULT (100) and invalid ACK values (000, 111, others) are never retried. They are reported verbatim.
- Minimum latency accept→rsp_valid: 4 clk plus engine transfer time.

Decomposition:
- Shared package swd_pkg: ACK_OK=3'b001, ACK_WAIT=3'b010, ACK_FAULT=3'b100; state encodings S_IDLE..S_RESP (3 bits).
- No sub-module needed. The watchdog is an inline counter.

Test Plan:
- Read DP addr32=0, engine model acks 001 with dread=32'h2BA01477, perr=0 → rsp_ack=001, rsp_rdata=32'h2BA01477, rsp_perr=0, rsp_retries=0, go asserted exactly once.
- Write AP addr32=1, wdata=32'h23000052, wait_retry=5, engine acks 010,010,001 → three go pulses, rsp_ack=001, rsp_retries=2, rsp_rdata=0, dwrite stable throughout.
- wait_retry=3, engine always acks 010 → four attempts, rsp_ack=010, rsp_retries=3.
- Engine acks 100 (FAULT) → single attempt, rsp_ack=100; read with perr=1 and ack 001 → rsp_perr=1.
- TOUT_CYCLES=100, engine idle never drops → go held 100 clk then cleared, rsp_timeout=1, rsp_ack=000; next command proceeds normally once idle=1.
- rsp_ready held low 50 cycles → rsp_valid and all rsp_* stable, cmd_ready=0. Also assert rst during S_BUSY → go=0, cmd_ready=0 that cycle, rsp_valid=0, S_IDLE after release.
